// File: rtl/exec_sequencer.sv
// Instruction-execution sequencer: decides when the current instruction retires
// (pc_inc), arbitrates the memory req/ack handshake and handles step/run/breakpoint.
module exec_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              user_clock,
  input  logic              run_mode,
  input  logic              stop_req,
  input  logic              clear_fault,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              needs_read,
  input  logic              needs_write,
  input  logic              mem_ack,
  output logic              pc_inc,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic              running,
  output logic              fault,
  output logic              bp_hit,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    STOPPED = 3'd0,
    ARMED   = 3'd1,
    EXEC    = 3'd2,
    RD_WAIT = 3'd3,
    WR_WAIT = 3'd4,
    FAULT   = 3'd5
  } state_t;

  // Value the counter holds during the last wait cycle before a timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              first, first_nxt;
  logic              bp_hit_nxt;
  state_t            retire_state;

  // Memory handshake: a request stays high from the first wait cycle until the
  // cycle mem_ack is seen; mem_ack is only honoured while a request is high.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= STOPPED;
      cnt    <= '0;
      first  <= 1'b0;
      bp_hit <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      first  <= first_nxt;
      bp_hit <= bp_hit_nxt;
    end
  end

  assign retire_state = (!run_mode || stop_req) ? STOPPED : EXEC;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    first_nxt  = first;
    bp_hit_nxt = bp_hit;
    pc_inc     = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    case (state)
      STOPPED: if (!user_clock) state_nxt = ARMED;
      ARMED: begin
        if (user_clock) begin
          state_nxt  = EXEC;
          first_nxt  = 1'b1;
          bp_hit_nxt = 1'b0;
        end
      end
      EXEC: begin
        // The first instruction after a start is exempt so a restart can step past the breakpoint.
        if (bp_en && (pc == bp_addr) && !first) begin
          state_nxt  = STOPPED;
          bp_hit_nxt = 1'b1;
        end else if (needs_read) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = '0;
        end else if (needs_write) begin
          state_nxt = WR_WAIT;
          cnt_nxt   = '0;
        end else begin
          pc_inc    = 1'b1;
          state_nxt = retire_state;
          first_nxt = 1'b0;
        end
      end
      RD_WAIT: begin
        mem_rd_req = 1'b1;
        if (mem_ack) begin
          if (needs_write) begin
            state_nxt = WR_WAIT;
            cnt_nxt   = '0;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = retire_state;
            first_nxt = 1'b0;
          end
        end else if (cnt == CNT_LAST) begin
          state_nxt = FAULT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WR_WAIT: begin
        mem_wr_req = 1'b1;
        if (mem_ack) begin
          pc_inc    = 1'b1;
          state_nxt = retire_state;
          first_nxt = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = FAULT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FAULT: if (clear_fault) state_nxt = STOPPED;
      default: state_nxt = STOPPED;
    endcase
  end

  assign running   = (state == EXEC) || (state == RD_WAIT) || (state == WR_WAIT);
  assign fault     = (state == FAULT);
  assign state_out = state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: hand-computed states and pulses per cycle.
module tb_exec_sequencer;

  logic        clock = 1'b0;
  logic        resetn, user_clock, run_mode, stop_req, clear_fault, bp_en;
  logic [15:0] bp_addr, pc;
  logic        needs_read, needs_write, mem_ack;
  logic        pc_inc, mem_rd_req, mem_wr_req, running, fault, bp_hit;
  logic [2:0]  state_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  exec_sequencer #(.ADDR_W(16), .TIMEOUT(15), .CNT_W(4)) dut (
    .clock(clock), .resetn(resetn), .user_clock(user_clock), .run_mode(run_mode),
    .stop_req(stop_req), .clear_fault(clear_fault), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .needs_read(needs_read), .needs_write(needs_write), .mem_ack(mem_ack),
    .pc_inc(pc_inc), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .running(running), .fault(fault), .bp_hit(bp_hit), .state_out(state_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs then change away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Settle combinational outputs after changing inputs mid-cycle.
  task automatic settle();
    #1;
  endtask

  task automatic start_seq(input string tag);
    user_clock = 1'b0;
    tick();
    check({tag, "_armed"}, state_out, 1);
    user_clock = 1'b1;
    tick();
    check({tag, "_exec"}, state_out, 2);
  endtask

  initial begin
    resetn = 0; user_clock = 1; run_mode = 1; stop_req = 0; clear_fault = 0;
    bp_en = 0; bp_addr = 16'h0005; pc = 16'h0000;
    needs_read = 0; needs_write = 0; mem_ack = 0;

    // Reset state
    tick(); tick();
    settle();
    check("rst_state", state_out, 0);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_reqs", {mem_rd_req, mem_wr_req}, 0);
    check("rst_flags", {running, fault, bp_hit}, 0);

    // Held user_clock high in STOPPED must not start
    resetn = 1;
    tick();
    check("hold_high_stopped", state_out, 0);

    // Free run with no memory access: pc_inc every EXEC cycle
    start_seq("run");
    for (int i = 0; i < 4; i++) begin
      settle();
      check("run_pc_inc", pc_inc, 1);
      check("run_running", running, 1);
      tick();
      check("run_state", state_out, 2);
    end
    run_mode = 0;
    settle();
    check("run_last_inc", pc_inc, 1);
    tick();
    check("run_stopped", state_out, 0);

    // Step mode read with ack in the third wait cycle
    needs_read = 1;
    start_seq("rd");
    settle();
    check("rd_exec_no_inc", pc_inc, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rd_state", state_out, 3);
      check("rd_req", {mem_rd_req, mem_wr_req}, 2'b10);
      check("rd_wait_no_inc", pc_inc, 0);
      tick();
    end
    mem_ack = 1; needs_read = 0;
    settle();
    check("rd_ack_req", mem_rd_req, 1);
    check("rd_ack_inc", pc_inc, 1);
    tick();
    mem_ack = 0;
    settle();
    check("rd_done_state", state_out, 0);
    check("rd_done_req", mem_rd_req, 0);

    // Read then write, ack in the first cycle of each wait
    needs_read = 1; needs_write = 1;
    start_seq("rw");
    tick();
    mem_ack = 1;
    settle();
    check("rw_rd_state", state_out, 3);
    check("rw_rd_ack_no_inc", pc_inc, 0);
    tick();
    settle();
    check("rw_wr_state", state_out, 4);
    check("rw_wr_req", {mem_rd_req, mem_wr_req}, 2'b01);
    check("rw_wr_ack_inc", pc_inc, 1);
    tick();
    mem_ack = 0; needs_read = 0; needs_write = 0;
    settle();
    check("rw_done_state", state_out, 0);

    // Write that never completes: FAULT after 15 wait cycles
    needs_write = 1;
    start_seq("to");
    tick();
    for (int i = 0; i < 15; i++) begin
      check("to_wait_state", state_out, 4);
      check("to_wait_inc", pc_inc, 0);
      tick();
    end
    check("to_fault_state", state_out, 5);
    check("to_fault_flags", {fault, running, mem_rd_req, mem_wr_req, pc_inc}, 5'b10000);
    tick();
    check("to_fault_held", state_out, 5);
    clear_fault = 1;
    tick();
    clear_fault = 0;
    check("to_cleared", state_out, 0);
    check("to_cleared_fault", fault, 0);

    // Ack in the final allowed wait cycle wins over the timeout
    start_seq("edge");
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("edge_still_wait", state_out, 4);
    mem_ack = 1;
    settle();
    check("edge_ack_inc", pc_inc, 1);
    tick();
    mem_ack = 0; needs_write = 0;
    check("edge_no_fault", state_out, 0);

    // Breakpoint at 0x0005 starting from 0x0003 in free run
    bp_en = 1; bp_addr = 16'h0005; pc = 16'h0003; run_mode = 1;
    start_seq("bp");
    settle();
    check("bp_inc_pc3", pc_inc, 1);
    tick(); pc = 16'h0004;
    settle();
    check("bp_inc_pc4", pc_inc, 1);
    tick(); pc = 16'h0005;
    settle();
    check("bp_no_inc_pc5", pc_inc, 0);
    tick();
    check("bp_stopped", state_out, 0);
    check("bp_hit_set", bp_hit, 1);
    run_mode = 0;
    user_clock = 0;
    tick();
    check("bp_hit_sticky", bp_hit, 1);
    user_clock = 1;
    tick();
    settle();
    check("bp_restart_state", state_out, 2);
    check("bp_hit_cleared", bp_hit, 0);
    check("bp_restart_inc", pc_inc, 1);
    tick();
    check("bp_restart_stopped", state_out, 0);
    bp_en = 0;

    // stop_req during a free-run read completes the instruction then stops
    run_mode = 1; needs_read = 1;
    start_seq("stop");
    tick();
    stop_req = 1;
    tick();
    check("stop_rd_state", state_out, 3);
    mem_ack = 1; needs_read = 0;
    settle();
    check("stop_ack_inc", pc_inc, 1);
    tick();
    mem_ack = 0; stop_req = 0;
    check("stop_stopped", state_out, 0);

    // Reset during a write wait drops the request with no retirement
    needs_write = 1;
    start_seq("rstw");
    tick();
    check("rstw_req", mem_wr_req, 1);
    resetn = 0;
    settle();
    check("rstw_no_inc", pc_inc, 0);
    tick();
    check("rstw_state", state_out, 0);
    check("rstw_req_drop", mem_wr_req, 0);
    resetn = 1; needs_write = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
